// File: rtl/vlane_element_sequencer.sv
// vlane_element_sequencer
//
// Issues the element groups of one vector instruction across the lanes.
// When a start is accepted, the vector length is captured from the control
// register file. The block then emits one element group per cycle. Each
// group carries an index, a lane-enable mask and a last flag.
// Emission holds under downstream stall. A one-cycle done pulse follows
// consumption of the final group.
//
// Configuration macro: VSEQ_ZERO_VL_SKIP_EN
//   defined   : a start with vl == 0 goes straight to DONE and emits no group.
//   undefined : vl == 0 emits a single group with an all-zero mask and last set.
//
// Ports:
//   clk           in   clock, all state changes on posedge
//   resetn        in   asynchronous active-low reset
//   vl            in   vector length, sampled only when a start is accepted
//   start         in   issue request for one vector instruction
//   start_ready   out  high only in IDLE
//   stall         in   downstream backpressure, holds the current group
//   grp_valid     out  current group outputs are valid
//   grp_index     out  0-based element group number (zero when not valid)
//   grp_lane_mask out  per-lane element enable (zero when not valid)
//   grp_last      out  current group is the final one
//   busy          out  high in RUN and DONE
//   done          out  one-cycle pulse after the last group is consumed
//
// Every output is decoded from registered state only. No combinational path
// runs from start, stall or vl to any output.

module vlane_element_sequencer #(
  parameter int unsigned NUMLANES     = 8,
  parameter int unsigned LOG2NUMLANES = 3,
  parameter int unsigned VLWIDTH      = 32
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [VLWIDTH-1:0]              vl,
  input  logic                            start,
  output logic                            start_ready,
  input  logic                            stall,
  output logic                            grp_valid,
  output logic [VLWIDTH-LOG2NUMLANES-1:0] grp_index,
  output logic [NUMLANES-1:0]             grp_lane_mask,
  output logic                            grp_last,
  output logic                            busy,
  output logic                            done
);

  // Width of a group index, and of a group count (one extra bit).
  localparam int unsigned GW = VLWIDTH - LOG2NUMLANES;
  localparam int unsigned NW = GW + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [VLWIDTH-1:0] vl_q, vl_d;
  logic [GW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     last_idx_q, last_idx_d;

  // Group count for the incoming vl is ceil(vl / NUMLANES). The extra bit
  // holds the carry, so the count cannot overflow at vl = 2^VLWIDTH-1.
  logic [NW-1:0] ngrp_in;
  logic [GW-1:0] last_idx_in;
  logic          vl_in_zero;

  always_comb begin
    ngrp_in    = {1'b0, vl[VLWIDTH-1:LOG2NUMLANES]} + NW'(|vl[LOG2NUMLANES-1:0]);
    vl_in_zero = (vl == '0);
    // ngrp never exceeds 2^GW, so ngrp-1 fits in GW bits. When vl == 0, the
    // single emitted group is index 0.
    if (ngrp_in == '0) begin
      last_idx_in = '0;
    end else begin
      last_idx_in = GW'(ngrp_in - NW'(1));
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    vl_d       = vl_q;
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          vl_d       = vl;
          cnt_d      = '0;
          last_idx_d = last_idx_in;
          state_d    = StRun;
`ifdef VSEQ_ZERO_VL_SKIP_EN
          if (vl_in_zero) begin
            state_d = StDone;
          end
`endif
        end
      end

      StRun: begin
        if (!stall) begin
          cnt_d = cnt_q + GW'(1);
          if (cnt_q == last_idx_q) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Only the skip build reads vl_in_zero. Fold it in here so the signal is
  // never left dangling in the default build.
  logic unused_vl_in_zero;
  assign unused_vl_in_zero = vl_in_zero;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      vl_q       <= '0;
      cnt_q      <= '0;
      last_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      vl_q       <= vl_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
    end
  end

  // Output decode from registered state
  logic                    run;
  logic                    is_last;
  logic [LOG2NUMLANES-1:0] rem;

  always_comb begin
    run     = (state_q == StRun);
    is_last = run && (cnt_q == last_idx_q);
    rem     = vl_q[LOG2NUMLANES-1:0];

    start_ready = (state_q == StIdle);
    busy        = (state_q == StRun) || (state_q == StDone);
    done        = (state_q == StDone);
    grp_valid   = run;
    grp_last    = is_last;
    grp_index   = run ? cnt_q : '0;

    grp_lane_mask = '0;
    if (run) begin
      if (!is_last) begin
        grp_lane_mask = '1;
      end else if (vl_q == '0) begin
        // vl == 0 emits one group with no active elements.
        grp_lane_mask = '0;
      end else if (rem == '0) begin
        grp_lane_mask = '1;
      end else begin
        // A partial final group enables the low (vl mod NUMLANES) lanes.
        for (int i = 0; i < NUMLANES; i++) begin
          grp_lane_mask[i] = (LOG2NUMLANES'(i) < rem);
        end
      end
    end
  end

endmodule

// File: tb/tb_vlane_element_sequencer.sv
// Directed self-checking bench for vlane_element_sequencer (NUMLANES = 8).
// Each cycle the bench compares one packed vector of all outputs:
// {start_ready, grp_valid, grp_last, busy, done, grp_index, grp_lane_mask}.

module tb_vlane_element_sequencer;

  localparam int unsigned NL = 8;
  localparam int unsigned LN = 3;
  localparam int unsigned VW = 32;
  localparam int unsigned GW = VW - LN;
  localparam int unsigned OW = 5 + GW + NL;

  logic          clk;
  logic          resetn;
  logic [VW-1:0] vl;
  logic          start;
  logic          start_ready;
  logic          stall;
  logic          grp_valid;
  logic [GW-1:0] grp_index;
  logic [NL-1:0] grp_lane_mask;
  logic          grp_last;
  logic          busy;
  logic          done;

  vlane_element_sequencer #(
    .NUMLANES    (NL),
    .LOG2NUMLANES(LN),
    .VLWIDTH     (VW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .vl           (vl),
    .start        (start),
    .start_ready  (start_ready),
    .stall        (stall),
    .grp_valid    (grp_valid),
    .grp_index    (grp_index),
    .grp_lane_mask(grp_lane_mask),
    .grp_last     (grp_last),
    .busy         (busy),
    .done         (done)
  );

  logic [OW-1:0] obs;
  assign obs = {start_ready, grp_valid, grp_last, busy, done, grp_index, grp_lane_mask};

  localparam logic [OW-1:0] ExpIdle = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 29'd0, 8'h00};
  localparam logic [OW-1:0] ExpDone = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 29'd0, 8'h00};

  int n_cmp;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start that is accepted at the next posedge (cycle N).
  // Returns in cycle N+1.
  task automatic do_start(input logic [VW-1:0] v);
    start = 1'b1;
    vl    = v;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [OW-1:0] exp;
    resetn = 1'b0;
    start  = 1'b0;
    stall  = 1'b0;
    vl     = '0;
    #2;
    exp = ExpIdle;
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", obs, exp);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_no_stall();
    int            vls[4]   = '{20, 16, 1, 9};
    int            ngrps[4] = '{3, 2, 1, 2};
    logic [7:0]    lastm[4] = '{8'h0F, 8'hFF, 8'h01, 8'h01};
    logic [OW-1:0] exp;
    logic [7:0]    m;
    logic          lst;
    for (int t = 0; t < 4; t++) begin
      do_start(VW'(vls[t]));
      for (int k = 0; k < ngrps[t]; k++) begin
        lst = (k == ngrps[t] - 1);
        m   = lst ? lastm[t] : 8'hFF;
        exp = {1'b0, 1'b1, lst, 1'b1, 1'b0, GW'(k), m};
        n_cmp++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL nostall vl=%0d grp%0d: got %h want %h", vls[t], k, obs, exp);
        end
        tick();
      end
      exp = ExpDone;
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL nostall_done vl=%0d: got %h want %h", vls[t], obs, exp);
      end
      tick();
      exp = ExpIdle;
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL nostall_idle vl=%0d: got %h want %h", vls[t], obs, exp);
      end
    end
  endtask

  // vl=20 with stall high for 3 cycles on group 1. vl changes mid-run.
  task automatic test_stall();
    logic [GW-1:0] idx[6] = '{29'd0, 29'd1, 29'd1, 29'd1, 29'd1, 29'd2};
    logic          stl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [OW-1:0] exp;
    do_start(32'd20);
    for (int c = 0; c < 6; c++) begin
      stall = stl[c];
      if (c == 2) vl = 32'd5;
      exp = {1'b0, 1'b1, (c == 5), 1'b1, 1'b0, idx[c], (c == 5) ? 8'h0F : 8'hFF};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL stall c%0d: got %h want %h", c + 1, obs, exp);
      end
      tick();
    end
    // A stall during DONE must not hold the done pulse.
    stall = 1'b1;
    exp = ExpDone;
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL stall_done: got %h want %h", obs, exp);
    end
    tick();
    exp = ExpIdle;
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL stall_idle: got %h want %h", obs, exp);
    end
    stall = 1'b0;
  endtask

  task automatic test_start_ignored();
    logic [OW-1:0] exp;
    do_start(32'd20);
    start = 1'b1;
    vl    = 32'd3;
    for (int k = 0; k < 3; k++) begin
      exp = {1'b0, 1'b1, (k == 2), 1'b1, 1'b0, GW'(k), (k == 2) ? 8'h0F : 8'hFF};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL ignstart grp%0d: got %h want %h", k, obs, exp);
      end
      tick();
    end
    exp = ExpDone;
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL ignstart_done: got %h want %h", obs, exp);
    end
    tick();
    start = 1'b0;
    exp = ExpIdle;
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL ignstart_idle: got %h want %h", obs, exp);
    end
    tick();
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL ignstart_idle2: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_zero_vl();
    logic [OW-1:0] exp;
    do_start(32'd0);
`ifdef VSEQ_ZERO_VL_SKIP_EN
    exp = ExpDone;
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL zerovl_skip_done: got %h want %h", obs, exp);
    end
`else
    exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 29'd0, 8'h00};
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL zerovl_grp: got %h want %h", obs, exp);
    end
    tick();
    exp = ExpDone;
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL zerovl_done: got %h want %h", obs, exp);
    end
`endif
    tick();
    exp = ExpIdle;
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL zerovl_idle: got %h want %h", obs, exp);
    end
  endtask

  // Maximum vl: 2^29 groups, no count overflow. Check the first groups, then abort with reset.
  task automatic test_max_vl();
    logic [OW-1:0] exp;
    do_start(32'hFFFF_FFFF);
    for (int k = 0; k < 2; k++) begin
      exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, GW'(k), 8'hFF};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL maxvl grp%0d: got %h want %h", k, obs, exp);
      end
      tick();
    end
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [OW-1:0] exp;
    do_start(32'd24);
    exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 29'd0, 8'hFF};
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL areset_grp0: got %h want %h", obs, exp);
    end
    tick();
    exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 29'd1, 8'hFF};
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL areset_grp1: got %h want %h", obs, exp);
    end
    #2;
    resetn = 1'b0;
    #1;
    exp = ExpIdle;
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL areset_immediate: got %h want %h", obs, exp);
    end
    tick();
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL areset_held: got %h want %h", obs, exp);
    end
    @(negedge clk);
    resetn = 1'b1;
    do_start(32'd8);
    exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 29'd0, 8'hFF};
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL areset_restart_grp: got %h want %h", obs, exp);
    end
    tick();
    exp = ExpDone;
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL areset_restart_done: got %h want %h", obs, exp);
    end
    tick();
    exp = ExpIdle;
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL areset_restart_idle: got %h want %h", obs, exp);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_no_stall();
    test_stall();
    test_start_ignored();
    test_zero_vl();
    test_max_vl();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
